iob_cache_write_burst_channel: RTL and testbench



---
 rtl/iob_cache_write_burst_channel_pkg.sv | 31 +++
 rtl/iob_cache_write_burst_channel_if.sv | 40 ++++
 rtl/iob_cache_write_burst_channel.sv | 141 ++++++++++++++
 tb/tb_iob_cache_write_burst_channel.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_write_burst_channel_pkg.sv
// Shared constants, state encoding and sizing helpers for the write burst channel.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package iob_cache_write_burst_channel_pkg;

    localparam int WRITE_THROUGH = 0;
    localparam int WRITE_BACK    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int nbytes(input int width);
        return width / 8;
    endfunction

    function automatic int log2c(input int value);
        return (value > 1) ? $clog2(value) : 0;
    endfunction

    // Beats per request: write-through always sends one beat, write-back
    // splits a line that is wider than the back-end bus.
    function automatic int burst_beats(input int pol, input int line_w, input int be_data_w);
        if (pol == WRITE_BACK && line_w > be_data_w) begin
            return line_w / be_data_w;
        end
        return 1;
    endfunction

endpackage

// File: rtl/iob_cache_write_burst_channel_if.sv
// Front-end write request plus back-end beat bus of the write burst channel.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the front end, be_valid/be_ready on the back end.
interface iob_cache_write_burst_channel_if
    import iob_cache_write_burst_channel_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int FE_DATA_W = 32,
    parameter int NBYTES    = 4,
    parameter int BE_ADDR_W = 32,
    parameter int BE_DATA_W = 128
);
    localparam int BE_NBYTES = nbytes(BE_DATA_W);

    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [NBYTES-1:0]     wstrb;
    logic [FE_DATA_W-1:0]  wdata;
    logic                  ready;

    logic                  be_valid;
    logic                  be_ready;
    logic [BE_ADDR_W-1:0]  be_addr;
    logic [BE_DATA_W-1:0]  be_wdata;
    logic [BE_NBYTES-1:0]  be_wstrb;
    logic                  be_last;

    // Requester side: issues writes and accepts beats.
    modport master (
        output valid, addr, wstrb, wdata, be_ready,
        input  ready, be_valid, be_addr, be_wdata, be_wstrb, be_last
    );

    // Channel side: accepts writes and issues beats.
    modport slave (
        input  valid, addr, wstrb, wdata, be_ready,
        output ready, be_valid, be_addr, be_wdata, be_wstrb, be_last
    );

endinterface

// File: rtl/iob_cache_write_burst_channel.sv
// Captures one cache write (word for write-through, dirty line for write-back) and emits it as back-end beats.
// Latency: first beat valid the cycle after acceptance; one beat per cycle while be_ready is high.
// Backpressure: beat fields hold while be_ready is low; a new request is taken only as the final beat leaves.
module iob_cache_write_burst_channel
    import iob_cache_write_burst_channel_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int BE_DATA_W     = 128,
    parameter int BE_ADDR_W     = 32,
    parameter int WORD_OFFSET_W = 3,
    parameter int WRITE_POL     = WRITE_THROUGH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    iob_cache_write_burst_channel_if.slave        bus,
    output logic                                  busy
);

    localparam int NBYTES     = nbytes(DATA_W);
    localparam int BE_NBYTES  = nbytes(BE_DATA_W);
    localparam int LINE_W     = DATA_W * (2 ** WORD_OFFSET_W);
    localparam int FE_DATA_W  = (WRITE_POL == WRITE_BACK) ? LINE_W : DATA_W;
    localparam int BEATS      = burst_beats(WRITE_POL, LINE_W, BE_DATA_W);
    localparam int CNT_W      = (BEATS > 1) ? log2c(BEATS) : 1;
    localparam int FE_OFF_W   = log2c(NBYTES);
    localparam int BE_OFF_W   = log2c(BE_NBYTES);
    localparam int LINE_OFF_W = log2c(LINE_W / 8);
    localparam int BASE_OFF_W = (LINE_OFF_W > BE_OFF_W) ? LINE_OFF_W : BE_OFF_W;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      cap_addr_q, cap_addr_d;
    logic [NBYTES-1:0]      cap_wstrb_q, cap_wstrb_d;
    logic [FE_DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
    logic [CNT_W-1:0]       beat_cnt;
    logic [BE_ADDR_W-1:0]   addr_ext;
    logic                   send;
    logic                   beat_fire;
    logic                   last;
    logic                   accept;
    logic                   unused_sink;

    assign send         = (state_q == ST_SEND);
    assign busy         = send;
    assign beat_fire    = send & bus.be_ready;
    // Ready while empty, or as the final beat leaves so bursts chain with no bubble.
    assign bus.ready    = ~send | (beat_fire & last);
    assign accept       = bus.valid & bus.ready;
    assign bus.be_valid = send;
    assign bus.be_last  = last;
    // Back-end addresses truncate or zero-extend the captured front-end address.
    assign addr_ext     = BE_ADDR_W'(cap_addr_q);
    assign unused_sink  = ^{cap_addr_q, cap_wstrb_q, cap_wdata_q, beat_cnt, addr_ext};

    // Next state and capture register: load on accept, empty after the final beat.
    always_comb begin
        state_d     = state_q;
        cap_addr_d  = cap_addr_q;
        cap_wstrb_d = cap_wstrb_q;
        cap_wdata_d = cap_wdata_q;
        if (accept) begin
            state_d     = ST_SEND;
            cap_addr_d  = bus.addr;
            cap_wstrb_d = bus.wstrb;
            cap_wdata_d = bus.wdata;
        end else if (beat_fire && last) begin
            state_d = ST_IDLE;
        end
    end

    // State and capture registers; reset drops any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cap_addr_q  <= '0;
            cap_wstrb_q <= '0;
            cap_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_wstrb_q <= cap_wstrb_d;
            cap_wdata_q <= cap_wdata_d;
        end
    end

    generate
        if (BEATS > 1) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Beat counter: cleared by a new request, advanced per accepted beat.
            always_comb begin
                cnt_d = cnt_q;
                if (accept) begin
                    cnt_d = '0;
                end else if (beat_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Beat counter register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign beat_cnt = cnt_q;
            assign last     = (cnt_q == CNT_W'(BEATS - 1));
        end else begin : g_no_cnt
            assign beat_cnt = '0;
            assign last     = 1'b1;
        end

        if (WRITE_POL == WRITE_BACK) begin : g_wb
            logic [31:0] data_shift;

            assign data_shift   = 32'(beat_cnt) * 32'(BE_DATA_W);
            assign bus.be_addr  = {addr_ext[BE_ADDR_W-1:BASE_OFF_W], BASE_OFF_W'(0)}
                                + (BE_ADDR_W'(beat_cnt) << BE_OFF_W);
            // A line narrower than the beat lands zero-extended in the low bits.
            assign bus.be_wdata = BE_DATA_W'(cap_wdata_q >> data_shift);
            // Whole-line writes enable every byte; held low while idle.
            assign bus.be_wstrb = {BE_NBYTES{send}};
        end else begin : g_wt
            logic [BE_NBYTES-1:0] strb_ext;

            assign strb_ext     = BE_NBYTES'(cap_wstrb_q);
            assign bus.be_addr  = {addr_ext[BE_ADDR_W-1:BE_OFF_W], BE_OFF_W'(0)};
            // The word is copied into every lane; the strobe picks the real one.
            assign bus.be_wdata = {(BE_DATA_W / DATA_W){cap_wdata_q}};
            if (BE_OFF_W > FE_OFF_W) begin : g_lane
                assign bus.be_wstrb = strb_ext << (NBYTES * int'(cap_addr_q[BE_OFF_W-1:FE_OFF_W]));
            end else begin : g_one_lane
                assign bus.be_wstrb = strb_ext;
            end
        end
    endgenerate

endmodule

// File: tb/tb_iob_cache_write_burst_channel.sv
// Scoreboard bench: write-through and write-back instances driven with directed and random writes.
// Latency: expected beats are queued on acceptance and checked when they leave the DUT.
// Backpressure: be_ready is toggled to exercise stalls and zero-bubble chaining.
module tb_iob_cache_write_burst_channel;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_wt;
    logic  rst_wb;
    logic  busy_wt;
    logic  busy_wb;
    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t q_wt[$];
    beat_t q_wb[$];
    logic  wt_stall = 1'b0;
    logic  wb_stall = 1'b0;
    beat_t wt_prev;
    beat_t wb_prev;

    always #5 clk = ~clk;

    iob_cache_write_burst_channel_if #(.ADDR_W(32), .FE_DATA_W(32), .NBYTES(4),
        .BE_ADDR_W(32), .BE_DATA_W(128)) wt ();
    iob_cache_write_burst_channel_if #(.ADDR_W(32), .FE_DATA_W(256), .NBYTES(4),
        .BE_ADDR_W(32), .BE_DATA_W(128)) wb ();

    iob_cache_write_burst_channel #(.ADDR_W(32), .DATA_W(32), .BE_DATA_W(128), .BE_ADDR_W(32),
        .WORD_OFFSET_W(3), .WRITE_POL(0)) u_wt (.clk(clk), .reset(rst_wt), .bus(wt), .busy(busy_wt));
    iob_cache_write_burst_channel #(.ADDR_W(32), .DATA_W(32), .BE_DATA_W(128), .BE_ADDR_W(32),
        .WORD_OFFSET_W(3), .WRITE_POL(1)) u_wb (.clk(clk), .reset(rst_wb), .bus(wb), .busy(busy_wb));

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        chk(name, 256'(got), 256'(exp));
    endtask

    // Reference: one beat holding the word in its lane of the 16-byte block.
    task automatic push_wt(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        beat_t b;
        b.addr = {a[31:4], 4'h0};
        b.data = {4{d}};
        b.strb = {12'h000, s} << (4 * a[3:2]);
        b.last = 1'b1;
        q_wt.push_back(b);
    endtask

    // Reference: a 32-byte line split into two 16-byte beats, low half first.
    task automatic push_wb(input logic [31:0] a, input logic [255:0] line);
        for (int i = 0; i < 2; i++) begin
            beat_t b;
            b.addr = {a[31:5], 5'h00} + 32'(16 * i);
            b.data = line[128*i +: 128];
            b.strb = 16'hFFFF;
            b.last = (i == 1);
            q_wb.push_back(b);
        end
    endtask

    // Drive one cycle from a falling edge; note acceptance and queue expectations.
    task automatic step_wt(input logic v, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic br, output logic acc);
        wt.valid = v; wt.addr = a; wt.wstrb = s; wt.wdata = d; wt.be_ready = br;
        #1;
        acc = v && wt.ready;
        if (acc) push_wt(a, s, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_wb(input logic v, input logic [31:0] a, input logic [255:0] line,
                           input logic br, output logic acc);
        wb.valid = v; wb.addr = a; wb.wstrb = 4'($urandom); wb.wdata = line; wb.be_ready = br;
        #1;
        acc = v && wb.ready;
        if (acc) push_wb(a, line);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic proto(input string nm, input logic vld, input logic bsy, input logic rdy,
                         input logic brdy, input beat_t cur, input logic was_stall, input beat_t prev);
        chkb({nm, "_busy"}, bsy, vld);
        chkb({nm, "_ready"}, rdy, !vld || (brdy && cur.last));
        if (was_stall) begin
            chkb({nm, "_hold_valid"}, vld, 1'b1);
            chk({nm, "_hold_fields"}, 256'(cur), 256'(prev));
        end
    endtask

    task automatic cmp_beat(input string nm, input beat_t cur, input beat_t exp);
        chk({nm, "_addr"}, 256'(cur.addr), 256'(exp.addr));
        chk({nm, "_data"}, 256'(cur.data), 256'(exp.data));
        chk({nm, "_strb"}, 256'(cur.strb), 256'(exp.strb));
        chkb({nm, "_last"}, cur.last, exp.last);
    endtask

    always @(negedge clk) begin : mon_wt
        beat_t cur;
        #2;
        cur.addr = wt.be_addr; cur.data = wt.be_wdata; cur.strb = wt.be_wstrb; cur.last = wt.be_last;
        if (rst_wt) begin
            wt_stall = 1'b0;
        end else begin
            proto("wt", wt.be_valid, busy_wt, wt.ready, wt.be_ready, cur, wt_stall, wt_prev);
            if (wt.be_valid && wt.be_ready) begin
                if (q_wt.size() == 0) chkb("wt_unexpected_beat", 1'b1, 1'b0);
                else cmp_beat("wt_beat", cur, q_wt.pop_front());
            end
            wt_stall = wt.be_valid && !wt.be_ready;
            wt_prev  = cur;
        end
    end

    always @(negedge clk) begin : mon_wb
        beat_t cur;
        #2;
        cur.addr = wb.be_addr; cur.data = wb.be_wdata; cur.strb = wb.be_wstrb; cur.last = wb.be_last;
        if (rst_wb) begin
            wb_stall = 1'b0;
        end else begin
            proto("wb", wb.be_valid, busy_wb, wb.ready, wb.be_ready, cur, wb_stall, wb_prev);
            if (wb.be_valid && wb.be_ready) begin
                if (q_wb.size() == 0) chkb("wb_unexpected_beat", 1'b1, 1'b0);
                else cmp_beat("wb_beat", cur, q_wb.pop_front());
            end
            wb_stall = wb.be_valid && !wb.be_ready;
            wb_prev  = cur;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic         acc;
        int           cnt;
        logic [255:0] line;

        rst_wt = 1'b1; rst_wb = 1'b1;
        wt.valid = 1'b0; wt.addr = '0; wt.wstrb = '0; wt.wdata = '0; wt.be_ready = 1'b0;
        wb.valid = 1'b0; wb.addr = '0; wb.wstrb = '0; wb.wdata = '0; wb.be_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state of both instances.
        chkb("wt_rst_ready", wt.ready, 1'b1);
        chkb("wt_rst_valid", wt.be_valid, 1'b0);
        chkb("wt_rst_busy", busy_wt, 1'b0);
        chk("wt_rst_wstrb", 256'(wt.be_wstrb), 256'(0));
        chkb("wb_rst_ready", wb.ready, 1'b1);
        chkb("wb_rst_valid", wb.be_valid, 1'b0);
        chkb("wb_rst_busy", busy_wb, 1'b0);
        chkb("wb_rst_last", wb.be_last, 1'b0);
        chk("wb_rst_wstrb", 256'(wb.be_wstrb), 256'(0));
        rst_wt = 1'b0; rst_wb = 1'b0;
        @(negedge clk);

        // Single write-through word in lane 1.
        step_wt(1'b1, 32'h104, 4'hF, 32'hDEADBEEF, 1'b1, acc);
        chkb("wt_dir_accept", acc, 1'b1);
        chkb("wt_dir_latency", wt.be_valid, 1'b1);
        chk("wt_dir_addr", 256'(wt.be_addr), 256'(32'h100));
        chk("wt_dir_strb", 256'(wt.be_wstrb), 256'(16'h00F0));
        chkb("wt_dir_last", wt.be_last, 1'b1);
        chkb("wt_dir_ready", wt.ready, 1'b1);
        step_wt(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, acc);

        // Back-to-back writes with no idle cycle.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step_wt(1'b1, $urandom, 4'($urandom), $urandom, 1'b1, acc);
            cnt += int'(acc);
        end
        chk("wt_b2b_accepts", 256'(cnt), 256'(8));
        step_wt(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, acc);

        // Five-cycle stall: nothing new accepted, beat held.
        step_wt(1'b1, 32'h20C, 4'h3, 32'hCAFEF00D, 1'b0, acc);
        chkb("wt_stall_first_accept", acc, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step_wt(1'b1, $urandom, 4'hF, $urandom, 1'b0, acc);
            chkb("wt_stall_noaccept", acc, 1'b0);
        end
        step_wt(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, acc);

        // Empty byte mask still produces one beat.
        step_wt(1'b1, 32'h108, 4'h0, 32'h12345678, 1'b1, acc);
        chkb("wt_zero_strb_accept", acc, 1'b1);
        step_wt(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, acc);

        for (int i = 0; i < 300; i++) begin
            step_wt(($urandom % 4) != 0, $urandom, 4'($urandom), $urandom, ($urandom % 3) != 0, acc);
        end
        for (int i = 0; i < 20 && q_wt.size() > 0; i++) step_wt(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, acc);
        chk("wt_drain_empty", 256'(q_wt.size()), 256'(0));
        chkb("wt_drain_idle", wt.be_valid, 1'b0);

        // Write-back line with be_ready 1,0,1.
        line = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
        step_wb(1'b1, 32'h200, line, 1'b1, acc);
        chkb("wb_dir_accept", acc, 1'b1);
        chkb("wb_dir_latency", wb.be_valid, 1'b1);
        chk("wb_dir_b0_addr", 256'(wb.be_addr), 256'(32'h200));
        step_wb(1'b0, 32'h0, '0, 1'b1, acc);
        chk("wb_dir_b1_addr", 256'(wb.be_addr), 256'(32'h210));
        chk("wb_dir_b1_data", 256'(wb.be_wdata), 256'(line[255:128]));
        chkb("wb_dir_b1_last", wb.be_last, 1'b1);
        step_wb(1'b0, 32'h0, '0, 1'b0, acc);
        step_wb(1'b0, 32'h0, '0, 1'b1, acc);
        chkb("wb_dir_idle", wb.be_valid, 1'b0);

        for (int i = 0; i < 200; i++) begin
            step_wb(($urandom % 3) != 0, $urandom, rand_line(), ($urandom % 3) != 0, acc);
        end
        for (int i = 0; i < 20 && q_wb.size() > 0; i++) step_wb(1'b0, 32'h0, '0, 1'b1, acc);
        chk("wb_drain_empty", 256'(q_wb.size()), 256'(0));

        // Reset while beat 0 is presented abandons the burst.
        step_wb(1'b1, 32'h300, rand_line(), 1'b0, acc);
        chkb("wb_rst_mid_accept", acc, 1'b1);
        chkb("wb_rst_mid_valid_before", wb.be_valid, 1'b1);
        wb.valid = 1'b0;
        rst_wb = 1'b1;
        #1;
        chkb("wb_rst_mid_valid", wb.be_valid, 1'b0);
        chkb("wb_rst_mid_busy", busy_wb, 1'b0);
        chkb("wb_rst_mid_ready", wb.ready, 1'b1);
        q_wb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_wb = 1'b0;
        chkb("wb_rst_after_valid", wb.be_valid, 1'b0);
        chkb("wb_rst_after_ready", wb.ready, 1'b1);
        line = rand_line();
        step_wb(1'b1, 32'h400, line, 1'b1, acc);
        chkb("wb_restart_accept", acc, 1'b1);
        chk("wb_restart_b0_addr", 256'(wb.be_addr), 256'(32'h400));
        chk("wb_restart_b0_data", 256'(wb.be_wdata), 256'(line[127:0]));
        for (int i = 0; i < 20 && q_wb.size() > 0; i++) step_wb(1'b0, 32'h0, '0, 1'b1, acc);
        chk("wb_final_empty", 256'(q_wb.size()), 256'(0));
        chkb("wb_final_idle", wb.be_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
